// File: rtl/amber_pkg.sv
// AMBER shared definitions: widths, opcodes, capability layout,
// system register indices and the core FSM state type.
package amber_pkg;

   localparam int WW  = 24;
   localparam int AW  = 48;
   localparam int MAW = 12;
   localparam int NCR = 4;
   localparam int NDR = 16;
   localparam int NSR = 4;

   localparam logic [7:0] OPC_NOP    = 8'h00;
   localparam logic [7:0] OPC_LUIUI  = 8'h01;
   localparam logic [7:0] OPC_MOVUI  = 8'h02;
   localparam logic [7:0] OPC_STCSO  = 8'h03;
   localparam logic [7:0] OPC_STUI   = 8'h04;
   localparam logic [7:0] OPC_STSI   = 8'h05;
   localparam logic [7:0] OPC_CLDCSO = 8'h06;
   localparam logic [7:0] OPC_CSTCSO = 8'h07;
   localparam logic [7:0] OPC_HLT    = 8'hFF;

   localparam int PERM_R  = 0;
   localparam int PERM_W  = 1;
   localparam int PERM_LC = 2;
   localparam int PERM_SC = 3;

   localparam int SR_IDX_PSTATE = 0;
   localparam int PSTATE_FAULT  = 0;

   localparam logic [3:0] CAP_WORDS = 4'd10;

   typedef struct packed {
      logic [AW-1:0] base;
      logic [AW-1:0] len;
      logic [AW-1:0] cur;
      logic [WW-1:0] perms;
      logic [WW-1:0] attr;
      logic          tag;
   } cap_t;

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_EXEC,
      ST_MEMOP,
      ST_HALT
   } state_t;

   function automatic logic [WW-1:0] perm_bit(input int b);
      return WW'(1) << b;
   endfunction

   // Word k of the in-memory capability record.
   function automatic logic [WW-1:0] cap_word(
      input cap_t       c,
      input logic [3:0] k
   );
      case (k)
         4'd0:    return c.base[WW-1:0];
         4'd1:    return c.base[AW-1:WW];
         4'd2:    return c.len[WW-1:0];
         4'd3:    return c.len[AW-1:WW];
         4'd4:    return c.cur[WW-1:0];
         4'd5:    return c.cur[AW-1:WW];
         4'd6:    return c.perms;
         4'd7:    return c.attr;
         4'd8:    return {{(WW-1){1'b0}}, c.tag};
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/amber_regcr.sv
// AMBER capability register file with the bounds and permission
// check used by every memory access.
module amber_regcr
   import amber_pkg::*;
(
   input  logic           r_clk,
   input  logic [1:0]     chk_idx,
   input  logic [AW-1:0]  chk_off,
   input  logic [3:0]     chk_n,
   input  logic [WW-1:0]  chk_need,
   output logic [MAW-1:0] chk_addr,
   output logic           chk_ok,
   input  logic [1:0]     src_idx,
   output cap_t           src_cap,
   input  logic           wr_en,
   input  logic [1:0]     wr_idx,
   input  cap_t           wr_cap
);

   logic [AW-1:0] r_base  [NCR];
   logic [AW-1:0] r_len   [NCR];
   logic [AW-1:0] r_cur   [NCR];
   logic [WW-1:0] r_perms [NCR];
   logic [WW-1:0] r_attr  [NCR];
   logic          r_tag   [NCR];

   logic [AW:0] w_a;
   logic [AW:0] w_end;
   logic [AW:0] w_lim;

   // One extra bit so a wrapped sum can never look in bounds.
   always_comb begin
      w_a   = {1'b0, r_cur[chk_idx]}
            + {chk_off[AW-1], chk_off};
      w_end = w_a + (AW+1)'(chk_n);
      w_lim = {1'b0, r_base[chk_idx]}
            + {1'b0, r_len[chk_idx]};
   end

   assign chk_addr = w_a[MAW-1:0];
   assign chk_ok   = r_tag[chk_idx]
                  && ({1'b0, r_base[chk_idx]} <= w_a)
                  && (w_end <= w_lim)
                  && ((r_perms[chk_idx] & chk_need)
                      == chk_need);

   assign src_cap.base  = r_base[src_idx];
   assign src_cap.len   = r_len[src_idx];
   assign src_cap.cur   = r_cur[src_idx];
   assign src_cap.perms = r_perms[src_idx];
   assign src_cap.attr  = r_attr[src_idx];
   assign src_cap.tag   = r_tag[src_idx];

   always_ff @(posedge r_clk) begin
      if (wr_en) begin
         r_base[wr_idx]  <= wr_cap.base;
         r_len[wr_idx]   <= wr_cap.len;
         r_cur[wr_idx]   <= wr_cap.cur;
         r_perms[wr_idx] <= wr_cap.perms;
         r_attr[wr_idx]  <= wr_cap.attr;
         r_tag[wr_idx]   <= wr_cap.tag;
      end
   end

endmodule

// File: rtl/amber.sv
// AMBER multicycle core: fetch/execute FSM, data registers,
// instruction/data memories and system registers.
module amber
   import amber_pkg::*;
(
   input logic iw_clk,
   input logic iw_rst
);

   state_t         r_state;
   state_t         w_state_nx;
   logic [MAW-1:0] r_pc;
   logic [WW-1:0]  r_ir;
   logic [3:0]     r_cnt;
   logic [MAW-1:0] r_addr;
   logic           r_pend;
   logic [11:0]    r_upper;
   logic [WW-1:0]  r_buf [10];
   logic [WW-1:0]  r_dr  [NDR];

   logic [7:0]     w_opc;
   logic [7:0]     w_wb_opc;
   logic [WW-1:0]  w_imm_u;
   logic [WW-1:0]  w_imm_s;
   logic [WW-1:0]  w_imem_q;
   logic [WW-1:0]  w_dm_q;
   logic [WW-1:0]  w_st_data;
   logic [WW-1:0]  w_dm_wdata;
   logic [MAW-1:0] w_dm_addr;
   logic           w_dm_we;
   logic           w_dr_we;
   logic           w_cr_we;
   logic           w_fault;
   logic           w_retire;

   logic [1:0]     w_chk_idx;
   logic [AW-1:0]  w_chk_off;
   logic [3:0]     w_chk_n;
   logic [WW-1:0]  w_chk_need;
   logic [MAW-1:0] w_chk_addr;
   logic           w_chk_ok;
   cap_t           w_src_cap;
   cap_t           w_cr_cap;

   logic w_is_lui, w_is_mov, w_is_stc, w_is_stu;
   logic w_is_sts, w_is_cld, w_is_cst, w_is_hlt;
   logic w_is_st, w_is_mem;

   assign w_opc    = r_ir[23:16];
   assign w_is_lui = (w_opc == OPC_LUIUI);
   assign w_is_mov = (w_opc == OPC_MOVUI);
   assign w_is_stc = (w_opc == OPC_STCSO);
   assign w_is_stu = (w_opc == OPC_STUI);
   assign w_is_sts = (w_opc == OPC_STSI);
   assign w_is_cld = (w_opc == OPC_CLDCSO);
   assign w_is_cst = (w_opc == OPC_CSTCSO);
   assign w_is_hlt = (w_opc == OPC_HLT);
   assign w_is_st  = w_is_stc | w_is_stu | w_is_sts;
   assign w_is_mem = w_is_st | w_is_cld | w_is_cst;

   assign w_imm_u = {r_pend ? r_upper : 12'h000,
                     r_ir[11:0]};
   assign w_imm_s = {{(WW-14){r_ir[13]}}, r_ir[13:0]};

   always_comb begin
      w_chk_idx  = r_ir[15:14];
      w_chk_off  = '0;
      w_chk_n    = 4'd1;
      w_chk_need = perm_bit(PERM_W);
      w_st_data  = w_imm_u;
      unique case (1'b1)
         w_is_stc: begin
            w_chk_off = {{(AW-10){r_ir[9]}}, r_ir[9:0]};
            w_st_data = r_dr[r_ir[13:10]];
         end
         w_is_sts: w_st_data = w_imm_s;
         w_is_cld: begin
            w_chk_idx  = r_ir[13:12];
            w_chk_off  = {{(AW-12){1'b0}}, r_ir[11:0]};
            w_chk_n    = CAP_WORDS;
            w_chk_need = perm_bit(PERM_R)
                       | perm_bit(PERM_LC);
         end
         w_is_cst: begin
            w_chk_off  = {{(AW-12){1'b0}}, r_ir[11:0]};
            w_chk_n    = CAP_WORDS;
            w_chk_need = perm_bit(PERM_W)
                       | perm_bit(PERM_SC);
         end
         default: ;
      endcase
   end

   assign w_cr_cap.base  = {r_buf[1], r_buf[0]};
   assign w_cr_cap.len   = {r_buf[3], r_buf[2]};
   assign w_cr_cap.cur   = {r_buf[5], r_buf[4]};
   assign w_cr_cap.perms = r_buf[6];
   assign w_cr_cap.attr  = r_buf[7];
   assign w_cr_cap.tag   = r_buf[8][0];

   amber_regcr u_regcr (
      .r_clk    (iw_clk),
      .chk_idx  (w_chk_idx),
      .chk_off  (w_chk_off),
      .chk_n    (w_chk_n),
      .chk_need (w_chk_need),
      .chk_addr (w_chk_addr),
      .chk_ok   (w_chk_ok),
      .src_idx  (r_ir[13:12]),
      .src_cap  (w_src_cap),
      .wr_en    (w_cr_we),
      .wr_idx   (r_ir[15:14]),
      .wr_cap   (w_cr_cap)
   );

   // Nothing commits while reset is held, so a reset
   // landing mid-CLD/CST simply abandons the op.
   always_comb begin
      w_state_nx = r_state;
      w_retire   = 1'b0;
      w_dm_we    = 1'b0;
      w_dm_addr  = w_chk_addr;
      w_dm_wdata = w_st_data;
      w_dr_we    = 1'b0;
      w_cr_we    = 1'b0;
      w_fault    = 1'b0;
      if (!iw_rst) begin
         unique case (r_state)
            ST_FETCH: w_state_nx = ST_EXEC;
            ST_EXEC: begin
               if (w_is_mem && !w_chk_ok) begin
                  w_fault    = 1'b1;
                  w_retire   = 1'b1;
                  w_state_nx = ST_FETCH;
               end else if (w_is_cld || w_is_cst) begin
                  w_state_nx = ST_MEMOP;
               end else begin
                  w_retire   = 1'b1;
                  w_dm_we    = w_is_st;
                  w_dr_we    = w_is_mov;
                  w_state_nx = w_is_hlt ? ST_HALT : ST_FETCH;
               end
            end
            ST_MEMOP: begin
               w_dm_addr  = r_addr + MAW'(r_cnt);
               w_dm_wdata = cap_word(w_src_cap, r_cnt);
               w_dm_we    = w_is_cst;
               if (r_cnt == CAP_WORDS - 4'd1) begin
                  w_retire   = 1'b1;
                  w_cr_we    = w_is_cld;
                  w_state_nx = ST_FETCH;
               end
            end
            ST_HALT: ;
            default: w_state_nx = ST_FETCH;
         endcase
      end
   end

   assign w_wb_opc =
      iw_rst ? OPC_NOP :
      (w_retire || r_state == ST_HALT) ? w_opc :
      OPC_NOP;

   always_ff @(posedge iw_clk) begin
      if (iw_rst) begin
         r_state <= ST_FETCH;
         r_pc    <= '0;
         r_pend  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         if (r_state == ST_FETCH)
            r_ir <= w_imem_q;
         if (r_state == ST_EXEC) begin
            r_cnt  <= '0;
            r_addr <= w_chk_addr;
            if (w_is_lui) begin
               r_upper <= r_ir[11:0];
               r_pend  <= 1'b1;
            end else if (w_is_mov || w_is_stu || w_is_sts) begin
               r_pend <= 1'b0;
            end
         end else if (r_state == ST_MEMOP) begin
            r_cnt <= r_cnt + 4'd1;
            if (w_is_cld)
               r_buf[r_cnt] <= w_dm_q;
         end
         if (w_retire)
            r_pc <= r_pc + 1'b1;
      end
   end

   always_ff @(posedge iw_clk) begin
      if (w_dr_we)
         r_dr[r_ir[15:12]] <= w_imm_u;
   end

   if (1) begin : u_imem
      logic [WW-1:0] r_mem [1<<MAW];
      assign w_imem_q = r_mem[r_pc];
   end

   if (1) begin : u_dmem
      logic [WW-1:0] r_mem [1<<MAW];
      always_ff @(posedge iw_clk) begin
         if (w_dm_we)
            r_mem[w_dm_addr] <= w_dm_wdata;
      end
      assign w_dm_q = r_mem[w_dm_addr];
   end

   if (1) begin : u_regsr
      logic [AW-1:0] r_sr [NSR];
      always_ff @(posedge iw_clk) begin
         if (w_fault)
            r_sr[SR_IDX_PSTATE] <= r_sr[SR_IDX_PSTATE]
                                 | (AW'(1) << PSTATE_FAULT);
      end
   end

endmodule

// File: tb/tb_amber.sv
// AMBER bench: directed program with per-retire expectations
// queued up front and checked by an independent monitor.
module tb_amber;
   import amber_pkg::*;

   logic iw_clk = 1'b0;
   logic iw_rst = 1'b1;

   always #5 iw_clk = ~iw_clk;

   amber dut (
      .iw_clk (iw_clk),
      .iw_rst (iw_rst)
   );

   typedef struct {
      int            idx;
      logic [7:0]    opc;
      logic          flt;
      int            kind;
      int            addr;
      logic [AW-1:0] val;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   bit   done   = 1'b0;

   task automatic check(
      input string         name,
      input logic [AW-1:0] act,
      input logic [AW-1:0] req
   );
      n_chk++;
      if (act === req)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, want 0x%0h",
                  name, act, req);
   endtask

   task automatic load(
      input int            idx,
      input logic [WW-1:0] ins,
      input logic          flt,
      input int            kind,
      input int            addr,
      input logic [AW-1:0] val
   );
      exp_t e;
      dut.u_imem.r_mem[idx] = ins;
      e.idx  = idx;
      e.opc  = ins[23:16];
      e.flt  = flt;
      e.kind = kind;
      e.addr = addr;
      e.val  = val;
      q.push_back(e);
   endtask

   task automatic set_cr(
      input int            i,
      input logic [AW-1:0] base,
      input logic [AW-1:0] len,
      input logic [AW-1:0] cur,
      input logic [WW-1:0] perms,
      input logic [WW-1:0] attr,
      input logic          tag
   );
      dut.u_regcr.r_base[i]  = base;
      dut.u_regcr.r_len[i]   = len;
      dut.u_regcr.r_cur[i]   = cur;
      dut.u_regcr.r_perms[i] = perms;
      dut.u_regcr.r_attr[i]  = attr;
      dut.u_regcr.r_tag[i]   = tag;
   endtask

   // Monitor: retire seen on one falling edge, its effects
   // checked on the next one.
   initial begin
      exp_t       e;
      logic [7:0] o;
      forever begin
         @(negedge iw_clk);
         if (!iw_rst && !done && dut.w_wb_opc != 8'h00) begin
            o = dut.w_wb_opc;
            if (q.size() == 0) begin
               n_chk++;
               $display("FAIL extra_retire: got 0x%0h, want none",
                        o);
            end else begin
               e = q.pop_front();
               check($sformatf("opc[%0d]", e.idx), o, e.opc);
               @(negedge iw_clk);
               check($sformatf("fault[%0d]", e.idx),
                     dut.u_regsr.r_sr[SR_IDX_PSTATE][PSTATE_FAULT],
                     e.flt);
               case (e.kind)
                  1: check($sformatf("dmem[%0d]", e.idx),
                           dut.u_dmem.r_mem[e.addr], e.val);
                  2: check($sformatf("dr[%0d]", e.idx),
                           dut.r_dr[e.addr], e.val);
                  3: check($sformatf("crbase[%0d]", e.idx),
                           dut.u_regcr.r_base[e.addr], e.val);
                  default: ;
               endcase
               if (e.opc == OPC_HLT)
                  done = 1'b1;
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 4096; i++) begin
         dut.u_imem.r_mem[i] = '0;
         dut.u_dmem.r_mem[i] = '0;
      end
      for (int i = 0; i < NDR; i++) dut.r_dr[i] = '0;
      for (int i = 0; i < NSR; i++) dut.u_regsr.r_sr[i] = '0;

      set_cr(0, 100, 32, 105, 24'h00000F, 0, 1'b1);
      set_cr(1, 200, 16, 204, 24'h000002, 0, 1'b1);
      set_cr(2, 300, 64, 300, 24'h000005, 0, 1'b1);
      set_cr(3, 48'h123456789ABC, 7, 9,
             24'h00A5A5, 24'h0055AA, 1'b1);

      dut.u_dmem.r_mem[300] = 24'd1234;
      dut.u_dmem.r_mem[301] = 24'd5678;
      dut.u_dmem.r_mem[302] = 24'd50;
      dut.u_dmem.r_mem[303] = 24'd0;
      dut.u_dmem.r_mem[304] = 24'd1240;
      dut.u_dmem.r_mem[305] = 24'd5678;
      dut.u_dmem.r_mem[306] = 24'h0000F0;
      dut.u_dmem.r_mem[307] = 24'h00000F;
      dut.u_dmem.r_mem[308] = 24'd1;
      dut.u_dmem.r_mem[309] = 24'd0;
      dut.u_dmem.r_mem[116] = 24'hDEAD01;
      dut.u_dmem.r_mem[132] = 24'h111111;

      load( 0, 24'h01000C, 0, 0,   0, 0);
      load( 1, 24'h0210DE, 0, 2,   1, 24'h00C0DE);
      load( 2, 24'h030401, 0, 1, 106, 24'h00C0DE);
      load( 3, 24'h010ABC, 0, 0,   0, 0);
      load( 4, 24'h044123, 0, 1, 204, 24'hABC123);
      load( 5, 24'h057FF8, 0, 1, 204, 24'hFFFFF8);
      load( 6, 24'h044055, 0, 1, 204, 24'h000055);
      load( 7, 24'h066000, 0, 3,   1,
            {24'd5678, 24'd1234});
      load( 8, 24'h073002, 0, 1, 113, 24'h00A5A5);
      load( 9, 24'h420000, 0, 0,   0, 0);
      load(10, 24'h03041A, 0, 1, 131, 24'h00C0DE);
      load(11, 24'h010777, 0, 0,   0, 0);
      load(12, 24'h050005, 0, 1, 105, 24'h000005);
      load(13, 24'h023001, 0, 2,   3, 24'h000001);
      load(14, 24'h048777, 1, 1, 300, 24'd1234);
      load(15, 24'h03041B, 1, 1, 132, 24'h111111);
      load(16, 24'hFF0000, 1, 0,   0, 0);

      repeat (3) @(posedge iw_clk);
      #1;
      check("rst_wb_opc", dut.w_wb_opc, OPC_NOP);
      check("rst_pc", dut.r_pc, 0);
      check("rst_state", dut.r_state, ST_FETCH);
      check("rst_pend", dut.r_pend, 0);

      @(negedge iw_clk);
      iw_rst = 1'b0;

      for (int c = 0; c < 800 && !done; c++)
         @(posedge iw_clk);

      if (!done) begin
         n_chk++;
         $display("FAIL halt_timeout: got no HLT, want HLT in 800");
      end else begin
         repeat (20) @(posedge iw_clk);
         #1;
         check("hlt_hold", dut.w_wb_opc, OPC_HLT);
         check("pc_frozen", dut.r_pc, 17);
         check("queue_empty", q.size(), 0);
         check("cr1_len", dut.u_regcr.r_len[1], 50);
         check("cr1_cur", dut.u_regcr.r_cur[1],
               {24'd5678, 24'd1240});
         check("cr1_perms", dut.u_regcr.r_perms[1], 24'hF0);
         check("cr1_attr", dut.u_regcr.r_attr[1], 24'h0F);
         check("cr1_tag", dut.u_regcr.r_tag[1], 1);
         check("cst_w0", dut.u_dmem.r_mem[107], 24'h789ABC);
         check("cst_w1", dut.u_dmem.r_mem[108], 24'h123456);
         check("cst_w2", dut.u_dmem.r_mem[109], 24'd7);
         check("cst_w4", dut.u_dmem.r_mem[111], 24'd9);
         check("cst_w7", dut.u_dmem.r_mem[114], 24'h0055AA);
         check("cst_w8", dut.u_dmem.r_mem[115], 24'd1);
         check("cst_w9", dut.u_dmem.r_mem[116], 24'd0);
      end

      @(negedge iw_clk);
      iw_rst = 1'b1;
      repeat (2) @(posedge iw_clk);
      #1;
      check("rst2_wb_opc", dut.w_wb_opc, OPC_NOP);
      check("rst2_pc", dut.r_pc, 0);
      check("rst2_state", dut.r_state, ST_FETCH);
      check("rst2_dr1", dut.r_dr[1], 24'h00C0DE);
      check("rst2_cr1_len", dut.u_regcr.r_len[1], 50);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/amber.md
AMBER -- requirements
Module: amber

Interface
REQ-001 Ports: iw_clk input 1 (sole clock, rising edge); iw_rst input 1 (reset, synchronous, active-high); no other ports.
REQ-002 Sizes: word 24 bits; address/capability fields 48 bits; opcode = instr[23:16]; opcode values come from shared opcode constants.
REQ-003 Hierarchy names (bench-visible): u_imem.r_mem, u_dmem.r_mem (each 4096 x 24, indexed by address[11:0]); u_regcr.r_base/r_len/r_cur (4 x 48), r_perms/r_attr (4 x 24), r_tag (4 x 1); u_regsr.r_sr (48-bit array indexed by SR_IDX_* constants); w_wb_opc (8).

Function
REQ-004 Execution is non-pipelined multicycle: FETCH (read imem[PC]), then EXEC; single-word ops retire in EXEC; PC increments by 1 on retire.
REQ-005 w_wb_opc equals the retiring opcode during its retire cycle, and 0 otherwise; after HLT it holds OPC_HLT permanently.
REQ-006 LUIui [15:14] bank, [11:0] imm12: latches upper12=imm12 and sets the pending flag.
REQ-007 Unsigned immediate for ui ops = {pending ? upper12 : 0, imm12}; each ui or si op clears pending.
REQ-008 MOVui [15:12] DRt, [11:0] imm12: DR[t] = unsigned immediate; 16 x 24-bit data registers.
REQ-009 STcso [15:14] CRb, [13:10] DRs, [9:0] signed imm10: dmem[cur+sext(imm10)] = DR[s].
REQ-010 STui [15:14] CRb, [11:0] imm12: dmem[cur] = unsigned immediate.
REQ-011 STsi [15:14] CRb, [13:0] imm14: dmem[cur] = sext(imm14) to 24 bits (0x3FF8 -> 0xFFFFF8).
REQ-012 CLDcso [15:14] CRt, [13:12] CRb, [11:0] imm12 zero-extended: reads 10 words from A = CRb.cur+imm, one per cycle.
REQ-013 CLD record layout: base = {w1,w0}; len = {w3,w2}; cur = {w5,w4}; perms = w6; attr = w7; tag = w8[0]; w9 reserved. CRt is written atomically after the last word.
REQ-014 CSTcso [15:14] CRb, [13:12] CRs, [11:0] imm12: writes CRs in the same 10-word layout at CRb.cur+imm, one word per cycle; w8 = {23'b0, tag}, w9 = 0.
REQ-015 Access check for every memory op, n = word count (1 or 10): CRb.tag = 1, base <= A, and A+n <= base+len.
REQ-016 Permissions: stores require PERM_W; loads require PERM_R; CLD additionally requires PERM_LC; CST additionally requires PERM_SC (bit indices from shared CR constants).
REQ-017 A failed check suppresses all writes of that op, sets the PSTATE fault bit in r_sr[SR_IDX_PSTATE], and the op still retires.
REQ-018 HLT stops fetching.
REQ-019 Unknown opcodes retire as NOP.

Reset
REQ-020 While iw_rst is high: PC = 0, state = FETCH, pending = 0, w_wb_opc = 0, halted = 0.
REQ-021 Reset does not clear DR, CR, SR or either memory, so state preloaded after reset release survives.
REQ-022 Reset asserted mid-CLD/CST aborts the op; words already stored remain, and CRt is not written.

Structure
REQ-023 Shared package/headers hold opcodes, CR perm bit indices, SR indices, PSTATE bits, and word/address widths.
REQ-024 One sub-module, amber_regcr (capability register file), handles the CR file plus the bounds/permission check.
REQ-025 The memories and data register file are simple arrays.

Verification
REQ-026 Setup: CR0 = [100,+32) cur 105, perms R|W|LC|SC. Program LUIui 0x00C; MOVui 0x0DE->DR1; STcso DR1,#1(CR0) -> mem[106] = 0x00C0DE.
REQ-027 Setup: CR1 = [200,+16) cur 204, perms W. LUIui 0xABC; STui #0x123 -> mem[204] = 0xABC123; then STsi #-8 -> mem[204] = 0xFFFFF8.
REQ-028 Setup: CR2 = [300,+64) cur 300, perms R|LC; mem[300..309] = 1234, 5678, 50, 0, 1240, 5678, 0xF0, 0x0F, 1, 0. CLDcso CR2 -> CR1: base = {5678,1234}, len 50, tag 1.
REQ-029 Setup: CR3 perms 0xA5A5, attr 0x55AA, tag 1. CSTcso CR3,#2(CR0) -> mem[113] = 0x00A5A5, mem[115][0] = 1.
REQ-030 Bounds/permission violations suppress the store and set the PSTATE fault bit: STui through a CR without W; STcso with offset beyond len.
REQ-031 HLT: w_wb_opc = OPC_HLT within 800 cycles and stays there; PC frozen.
